alert_channel_scheduler: RTL
============================

// Module: alert_channel_scheduler
// PURPOSE
//  Shares the single caregiver notification channel (buzzer/radio link) among four alert
//  sources: fall alarm, BPM-abnormal, temperature-abnormal and medicine reminder. Latches
//  each source's event, picks one by priority/round-robin, offers it over a valid/ready
//  handshake, holds the announcement, then waits for the caregiver acknowledge. Sits between
//  the monitor blocks and the channel driver.
// PARAMETERS
//  HOLD_CYCLES      16   cycles ALERT is held after the channel accepts it (>=1)
//  COOLDOWN_CYCLES  4    idle gap after an ack before the next grant (>=1)
//  ESC_CYCLES       64   WAIT_ACK cycles before escalation (ALERT_ESCALATE_EN only, >=1)
//  CNT_W            8    timer width; must hold max(HOLD,COOLDOWN,ESC)
// PORTS
//  clk            in   1  system clock; only clock in the block
//  reset          in   1  asynchronous, active-low reset
//  req            in   4  alert levels: [0]=fall [1]=bpm [2]=temp [3]=medicine
//  mask           in   4  1 = source not granted; events are still latched
//  ch_ready       in   1  channel driver can accept an alert
//  caregiver_ack  in   1  single-cycle acknowledge pulse
//  ch_valid       out  1  alert offered to the channel
//  ch_src         out  2  index of the offered/active source
//  pending        out  4  latched, unacknowledged events
//  busy           out  1  state != IDLE
//  escalate       out  1  unacknowledged-alert escalation flag
// BEHAVIOUR
//  Reset (reset=0): state=IDLE; ch_valid=0, ch_src=0, pending=0, busy=0, escalate=0,
//   rr_ptr=1, req edge-detect registers=0, timers=0. Applies immediately, including mid-alert.
//  Event latch:
//   - A rising edge of req[i] (registered edge detect) sets pending[i] on the next clk.
//   - Set beats clear: an edge in the same cycle as the ack of source i leaves pending[i]=1.
//  Selection (eligible = pending & ~mask):
//   - Source 0 always wins.
//   - Otherwise round-robin over 1..3, starting at rr_ptr.
//   - After each grant of source 1..3, rr_ptr moves to the next source, wrapping 3 -> 1.
//  FSM:
//   - IDLE: if eligible!=0, latch sel into ch_src -> OFFER next cycle.
//   - OFFER: ch_valid=1. ch_src is held stable while ch_valid=1 && ch_ready=0.
//     On ch_valid&&ch_ready: ch_valid=0, load timer=HOLD_CYCLES -> ANNOUNCE.
//   - ANNOUNCE: timer decrements each cycle; at 0 -> WAIT_ACK.
//   - WAIT_ACK: on caregiver_ack: clear pending[ch_src], load timer=COOLDOWN_CYCLES -> COOLDOWN.
//   - COOLDOWN: timer decrements; at 0 -> IDLE. Grant latency is 1 cycle IDLE->OFFER.
//  Ack rules: caregiver_ack outside WAIT_ACK is ignored and clears nothing.
//  Preemption:
//   - In ANNOUNCE or WAIT_ACK with ch_src!=0: if eligible[0] rises, abandon the current alert
//     (its pending bit stays set; rr_ptr unchanged), ch_src=0 -> OFFER.
//   - OFFER is never preempted.
//  Masking mid-alert: setting mask[ch_src] after the grant does not abort the alert.
//  All sources masked or none pending: the FSM stays in IDLE and pending keeps latching.
// CONFIGURATION
//  ALERT_ESCALATE_EN defined:
//   - A WAIT_ACK counter reaching ESC_CYCLES sets escalate=1 (sticky) and re-enters OFFER
//     with the same ch_src (re-announce).
//   - escalate clears on the accepted caregiver_ack or on reset.
//  ALERT_ESCALATE_EN undefined: escalate tied to 0; WAIT_ACK waits indefinitely.
// STRUCTURE
//  Shared package/header alert_pkg.vh holds:
//   - state encodings: IDLE, OFFER, ANNOUNCE, WAIT_ACK, COOLDOWN;
//   - source indices: SRC_FALL=0, SRC_BPM=1, SRC_TEMP=2, SRC_MED=3;
//   - NUM_SRC=4.
//  One sub-module, alert_timer: loadable CNT_W down-counter with zero flag. One instance
//  serves HOLD/COOLDOWN; a second serves the ESC count.
// TESTING
//  1. req[2] 0->1, ch_ready=1 -> pending=0100; ch_valid=1, ch_src=2 two cycles after the
//     edge; ACK wait after 16 cycles; ack -> pending=0000; IDLE after 4 more cycles.
//  2. req[1] and req[3] rise together, rr_ptr=1 -> src 1 served first, then src 3
//     (rr_ptr=2 after the first grant); both pending bits clear in order.
//  3. ch_ready=0 for 10 cycles during OFFER -> ch_valid=1 and ch_src stable all 10 cycles;
//     ANNOUNCE starts the cycle after ch_ready=1.
//  4. Serving src 3 in WAIT_ACK, req[0] rises -> ch_src=0, OFFER; pending=1001; after the
//     fall alert is acked, src 3 is re-granted.
//  5. ack in ANNOUNCE -> ignored. reset=0 mid-ANNOUNCE -> all outputs 0 immediately.
//     mask=0001 with req[0] -> pending[0]=1, no grant.
//  6. ALERT_ESCALATE_EN, no ack for 64 cycles -> escalate=1, re-OFFER same src; ack ->
//     escalate=0. Without the macro, escalate stays 0 after 200 cycles.

Source files
------------

// File: rtl/alert_channel_scheduler_pkg.sv
// Shared types and helpers for the caregiver alert channel scheduler.
package alert_channel_scheduler_pkg;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned SRC_W   = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OFFER    = 3'd1,
        ANNOUNCE = 3'd2,
        WAIT_ACK = 3'd3,
        COOLDOWN = 3'd4
    } state_e;

    localparam logic [SRC_W-1:0] SRC_FALL = 2'd0;
    localparam logic [SRC_W-1:0] SRC_BPM  = 2'd1;
    localparam logic [SRC_W-1:0] SRC_TEMP = 2'd2;
    localparam logic [SRC_W-1:0] SRC_MED  = 2'd3;

    // Round-robin successor among the non-fall sources, wrapping medicine back to bpm.
    function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] src);
        case (src)
            SRC_BPM:  rr_next = SRC_TEMP;
            SRC_TEMP: rr_next = SRC_MED;
            default:  rr_next = SRC_BPM;
        endcase
    endfunction

    // First eligible source among 1..3 starting at ptr.
    function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_SRC-1:0] elig,
                                                 input logic [SRC_W-1:0]   ptr);
        logic [SRC_W-1:0] cand;
        logic             found;
        rr_pick = SRC_BPM;
        cand    = ptr;
        found   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!found && elig[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
            cand = rr_next(cand);
        end
    endfunction

endpackage

// File: rtl/alert_timer.sv
// Loadable down-counter with a registered zero flag; holds at zero.
module alert_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            count <= load_val;
            zero  <= (load_val == '0);
        end else if (dec && !zero) begin
            count <= count - CNT_W'(1);
            zero  <= (count == CNT_W'(1));
        end
    end

endmodule

// File: rtl/alert_channel_scheduler.sv
// Shares one caregiver notification channel among four latched alert sources.
// Optional feature: define ALERT_ESCALATE_EN to re-announce unacknowledged alerts.
module alert_channel_scheduler
    import alert_channel_scheduler_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned COOLDOWN_CYCLES = 4,
    parameter int unsigned ESC_CYCLES      = 64,
    parameter int unsigned CNT_W           = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] mask,
    input  logic               ch_ready,
    input  logic               caregiver_ack,
    output logic               ch_valid,
    output logic [SRC_W-1:0]   ch_src,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy,
    output logic               escalate
);

    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    if (HOLD_CYCLES < 1 || COOLDOWN_CYCLES < 1 || ESC_CYCLES < 1 ||
        HOLD_CYCLES > CNT_MAX || COOLDOWN_CYCLES > CNT_MAX || ESC_CYCLES > CNT_MAX) begin : g_bad_param
        $error("alert_channel_scheduler: cycle parameters must be >=1 and fit CNT_W");
    end

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] req_q, rise, eligible, clr;
    logic [SRC_W-1:0]   rr_ptr, rr_d, src_d;
    logic               valid_d, preempt;
    logic               t_load, t_dec, t_zero;
    logic [CNT_W-1:0]   t_val;
`ifdef ALERT_ESCALATE_EN
    logic               e_load, e_dec, e_zero, esc_set, esc_clr;
`endif

    assign rise     = req & ~req_q;
    assign eligible = pending & ~mask;
    assign preempt  = (ch_src != SRC_FALL) && eligible[SRC_FALL];

    // Timers load N-1 so that each timed state lasts exactly N cycles.
    always_comb begin
        state_d = state_q;
        src_d   = ch_src;
        valid_d = ch_valid;
        rr_d    = rr_ptr;
        clr     = '0;
        t_load  = 1'b0;
        t_dec   = 1'b0;
        t_val   = '0;
`ifdef ALERT_ESCALATE_EN
        e_load  = 1'b0;
        e_dec   = 1'b0;
        esc_set = 1'b0;
        esc_clr = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    src_d = eligible[SRC_FALL] ? SRC_FALL : rr_pick(eligible, rr_ptr);
                    if (src_d != SRC_FALL) rr_d = rr_next(src_d);
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (ch_ready) begin
                    valid_d = 1'b0;
                    t_load  = 1'b1;
                    t_val   = CNT_W'(HOLD_CYCLES - 1);
                    state_d = ANNOUNCE;
                end
            end
            ANNOUNCE: begin
                if (preempt) begin
                    src_d   = SRC_FALL;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end else if (t_zero) begin
                    state_d = WAIT_ACK;
`ifdef ALERT_ESCALATE_EN
                    e_load  = 1'b1;
`endif
                end else begin
                    t_dec = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (caregiver_ack) begin
                    clr[ch_src] = 1'b1;
                    t_load      = 1'b1;
                    t_val       = CNT_W'(COOLDOWN_CYCLES - 1);
                    state_d     = COOLDOWN;
`ifdef ALERT_ESCALATE_EN
                    esc_clr     = 1'b1;
`endif
                end else if (preempt) begin
                    src_d   = SRC_FALL;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
`ifdef ALERT_ESCALATE_EN
                else if (e_zero) begin
                    esc_set = 1'b1;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end else begin
                    e_dec = 1'b1;
                end
`endif
            end
            COOLDOWN: begin
                if (t_zero) state_d = IDLE;
                else        t_dec   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // A new edge wins over a same-cycle ack clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            req_q    <= '0;
            pending  <= '0;
            ch_valid <= 1'b0;
            ch_src   <= SRC_FALL;
            busy     <= 1'b0;
            rr_ptr   <= SRC_BPM;
        end else begin
            state_q  <= state_d;
            req_q    <= req;
            pending  <= (pending & ~clr) | rise;
            ch_valid <= valid_d;
            ch_src   <= src_d;
            busy     <= (state_d != IDLE);
            rr_ptr   <= rr_d;
        end
    end

    alert_timer #(.CNT_W(CNT_W)) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .zero     (t_zero)
    );

`ifdef ALERT_ESCALATE_EN
    alert_timer #(.CNT_W(CNT_W)) u_esc_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (e_load),
        .load_val (CNT_W'(ESC_CYCLES - 1)),
        .dec      (e_dec),
        .zero     (e_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       escalate <= 1'b0;
        else if (esc_clr) escalate <= 1'b0;
        else if (esc_set) escalate <= 1'b1;
    end
`else
    assign escalate = 1'b0;
`endif

endmodule
